// File: rtl/ps2_tone_synth_if.sv
// Purpose: bundles the scan-code strobe from the PS/2 receiver with the tone and status outputs.
// Ports: scan_valid/scan_code flow into the synth; pwm_out, half_period, note_active,
//        note_idx, octave and muted flow out to the audio pin and display logic.
interface ps2_tone_synth_if #(
  parameter int HP_W = 20
) ();
  logic            scan_valid;
  logic [7:0]      scan_code;
  logic            pwm_out;
  logic [HP_W-1:0] half_period;
  logic            note_active;
  logic [2:0]      note_idx;
  logic [1:0]      octave;
  logic            muted;

  // master = scan-code source / status consumer, slave = the tone synth
  modport master (
    output scan_valid, scan_code,
    input  pwm_out, half_period, note_active, note_idx, octave, muted
  );
  modport slave (
    input  scan_valid, scan_code,
    output pwm_out, half_period, note_active, note_idx, octave, muted
  );
endinterface

// File: rtl/ps2_tone_synth.sv
// Purpose: decodes PS/2 set-2 make/break/extended bytes into note, octave and mute state and
//          drives a square wave whose levels each last exactly half_period cycles.
// Latency: status registers update one edge after the strobe; half_period is combinational from them.
// Backpressure: none; every strobed byte is consumed in its cycle.
// Ports: clk, reset (sync, active-low), bus (slave side of ps2_tone_synth_if).
module ps2_tone_synth #(
  parameter int HP_W     = 20,
  parameter int OCT_MAX  = 3,
  parameter bit SHIFT_EN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  ps2_tone_synth_if.slave bus
);

  localparam logic [1:0] OCT_MAX_L = 2'(OCT_MAX);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BREAK, S_EXT_BREAK} state_t;

  state_t          state, state_nxt;
  logic            is_make, is_break;
  logic            key_note, key_shift;
  logic [2:0]      key_idx;
  logic            note_active_q, shift_held, z_held, x_held, mute_held, muted_q;
  logic [2:0]      note_idx_q;
  logic [1:0]      oct_reg, oct_eff;
  logic [2:0]      oct_sum;
  logic [31:0]     tbl_raw;
  logic [HP_W-1:0] hp_now, hp_q, cnt;
  logic            pwm_q;

  // Decoder state register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Decoder next state; flags a plain make or a plain break for the key logic
  always_comb begin
    state_nxt = state;
    is_make   = 1'b0;
    is_break  = 1'b0;
    if (bus.scan_valid) begin
      case (state)
        S_IDLE: begin
          if (bus.scan_code == 8'hE0)      state_nxt = S_EXT;
          else if (bus.scan_code == 8'hF0) state_nxt = S_BREAK;
          else                             is_make   = 1'b1;
        end
        S_EXT:       state_nxt = (bus.scan_code == 8'hF0) ? S_EXT_BREAK : S_IDLE;
        S_BREAK: begin
          is_break  = 1'b1;
          state_nxt = S_IDLE;
        end
        S_EXT_BREAK: state_nxt = S_IDLE;
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  // Note key lookup
  always_comb begin
    key_note = 1'b1;
    key_idx  = 3'd0;
    case (bus.scan_code)
      8'h23:   key_idx = 3'd0;
      8'h2D:   key_idx = 3'd1;
      8'h3A:   key_idx = 3'd2;
      8'h2B:   key_idx = 3'd3;
      8'h1B:   key_idx = 3'd4;
      8'h4B:   key_idx = 3'd5;
      8'h21:   key_idx = 3'd6;
      default: key_note = 1'b0;
    endcase
  end

  assign key_shift = (bus.scan_code == 8'h12) || (bus.scan_code == 8'h59);

  // Key state. Held flags make octave/mute act on the first make only, so typematic repeats are inert.
  always_ff @(posedge clk) begin
    if (!reset) begin
      note_active_q <= 1'b0;
      note_idx_q    <= 3'd0;
      shift_held    <= 1'b0;
      z_held        <= 1'b0;
      x_held        <= 1'b0;
      mute_held     <= 1'b0;
      muted_q       <= 1'b0;
      oct_reg       <= 2'd0;
    end else begin
      if (is_make) begin
        if (key_note) begin
          note_active_q <= 1'b1;
          note_idx_q    <= key_idx;
        end
        if (key_shift) shift_held <= 1'b1;
        if (bus.scan_code == 8'h1A) begin
          if (!z_held && oct_reg != 2'd0) oct_reg <= oct_reg - 2'd1;
          z_held <= 1'b1;
        end
        if (bus.scan_code == 8'h22) begin
          if (!x_held && oct_reg < OCT_MAX_L) oct_reg <= oct_reg + 2'd1;
          x_held <= 1'b1;
        end
        if (bus.scan_code == 8'h0D) begin
          if (!mute_held) muted_q <= ~muted_q;
          mute_held <= 1'b1;
        end
      end
      if (is_break) begin
        // only releasing the latched note silences it
        if (key_note && note_active_q && key_idx == note_idx_q) begin
          note_active_q <= 1'b0;
          note_idx_q    <= 3'd0;
        end
        if (key_shift)               shift_held <= 1'b0;
        if (bus.scan_code == 8'h1A) z_held     <= 1'b0;
        if (bus.scan_code == 8'h22) x_held     <= 1'b0;
        if (bus.scan_code == 8'h0D) mute_held  <= 1'b0;
      end
    end
  end

  // Shift boost saturates at the same ceiling as the octave register
  assign oct_sum = {1'b0, oct_reg} + {2'b00, SHIFT_EN & shift_held};
  assign oct_eff = (oct_sum > {1'b0, OCT_MAX_L}) ? OCT_MAX_L : oct_sum[1:0];

  // Octave-0 half periods at 100 MHz
  always_comb begin
    case (note_idx_q)
      3'd0:    tbl_raw = 32'd191116;
      3'd1:    tbl_raw = 32'd170264;
      3'd2:    tbl_raw = 32'd151689;
      3'd3:    tbl_raw = 32'd143172;
      3'd4:    tbl_raw = 32'd127551;
      3'd5:    tbl_raw = 32'd113636;
      3'd6:    tbl_raw = 32'd101239;
      default: tbl_raw = 32'd0;
    endcase
  end

  assign hp_now = note_active_q ? (HP_W'(tbl_raw) >> oct_eff) : '0;

  // Tone generator. Any change of half_period (seen as hp_now != hp_q) restarts from low so a
  // retune never produces a short or long level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hp_q  <= '0;
      cnt   <= '0;
      pwm_q <= 1'b0;
    end else begin
      hp_q <= hp_now;
      if (muted_q || hp_now == '0 || hp_now != hp_q) begin
        cnt   <= '0;
        pwm_q <= 1'b0;
      end else if (cnt == hp_now - HP_W'(1)) begin
        cnt   <= '0;
        pwm_q <= ~pwm_q;
      end else begin
        cnt <= cnt + HP_W'(1);
      end
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.half_period = hp_now;
  assign bus.note_active = note_active_q;
  assign bus.note_idx    = note_idx_q;
  assign bus.octave      = oct_eff;
  assign bus.muted       = muted_q;

endmodule

// File: doc/ps2_tone_synth.md
Name: ps2_tone_synth

Overview:
- Parametrised successor to the keyboard tone generator. Consumes PS/2 scan-code bytes from the keyboard receiver and fully decodes make/break/extended sequences.
- Tracks the held note, octave and mute state, and drives a square-wave audio output with an exact half-period.
- Sits between the PS/2 receiver and the audio pin; also exports note status for the display logic.

Parameters:
- HP_W, 20: width of the half-period and tone counter, in clock cycles.
- OCT_MAX, 3: highest octave offset. The octave register and the shift-boosted octave saturate at this value.
- SHIFT_EN, 1: 1 = a held Shift key raises the octave by one; 0 = Shift is ignored.

Ports:
- clk, in, 1: 100 MHz system clock.
- reset, in, 1: synchronous, active-low reset (reset==0 sampled on posedge clk resets the block).
- scan_valid, in, 1: one-cycle strobe; scan_code is valid this cycle.
- scan_code, in, 8: received PS/2 set-2 byte.
- pwm_out, out, 1: square-wave audio output.
- half_period, out, HP_W: half-period currently in effect; 0 = silent.
- note_active, out, 1: a note key is currently latched.
- note_idx, out, 3: latched note, 0=C … 6=B; 0 when none.
- octave, out, 2: effective octave offset, including shift.
- muted, out, 1: mute toggle state.

Behaviour:
- Reset (reset==0 at a clock edge): all outputs and internal registers go to 0, and the decoder goes to S_IDLE. This takes priority over every other event, including one mid-sequence.
- Decoder FSM. It advances only on cycles with scan_valid=1.
  - S_IDLE: E0 -> S_EXT; F0 -> S_BREAK; any other byte is processed as a make, stay in S_IDLE.
  - S_EXT: F0 -> S_EXT_BREAK; any other byte is ignored (extended make) -> S_IDLE.
  - S_BREAK: byte processed as a break -> S_IDLE.
  - S_EXT_BREAK: byte ignored -> S_IDLE.
- Note keys: 23=C, 2D=D, 3A=E, 2B=F, 1B=G, 4B=A, 21=B.
  - Make latches note_idx and sets note_active; last-pressed wins.
  - A repeat make of the same key changes nothing.
  - Break of the latched key clears note_active and note_idx. Break of any other note key is ignored.
- Shift (12 or 59):
  - Make sets shift_held; break clears it.
  - Effective octave = min(oct_reg + (SHIFT_EN & shift_held), OCT_MAX).
- Octave keys: 1A (Z) decrements oct_reg, 22 (X) increments it, saturating at 0 and OCT_MAX.
  - Each key steps only on its first make. Per-key held flags suppress typematic repeats and clear on that key's break.
- Mute key 0D:
  - First make toggles muted. Repeat makes are ignored via mute_held, which clears on break.
  - Break of 0D does not toggle.
- Unknown bytes, and AA/FA/FE received in S_IDLE, are ignored.
- Latency:
  - scan_valid at cycle n -> note_idx, note_active, octave and muted update at edge n+1.
  - half_period is combinational from those registers, so it is also valid at n+1.
- Half-period table, octave 0 (100 MHz clock): C=191116, D=170264, E=151689, F=143172, G=127551, A=113636, B=101239.
  - half_period = table[note_idx] >> octave when note_active, else 0.
  - The top bits of table values are zero-extended or truncated to HP_W.
- Tone generator:
  - Registered hp_q copies half_period every cycle.
  - If muted==1 or half_period==0, or if half_period != hp_q: counter <= 0 and pwm_out <= 0 (restart, no glitch).
  - Otherwise: if counter == half_period-1, counter <= 0 and pwm_out toggles; else counter <= counter+1.
  - Each pwm_out level therefore lasts exactly half_period cycles in steady state.
- Simultaneous events are impossible because there is one byte per strobe.
- Muting keeps the note and octave state. Unmuting resumes the tone from the restart condition: pwm_out low for the first half_period cycles.

Test Plan:
1. Reset low 2 cycles, then send 23 -> at n+1 half_period=191116, note_idx=0, note_active=1. pwm_out is low for 191116 cycles, then high for 191116 cycles.
2. Send 12, then 2D -> octave=1, half_period=85132. Send F0,12 -> octave=0, half_period=170264, and the counter restarts with pwm_out=0 on the change cycle.
3. Send 22,22,22,22 (with F0,22 between each press) -> octave saturates at 3. Hold 4B -> half_period=14204. Then 1A press/release x4 -> octave=0.
4. Hold 21, send 1B, then F0,21 -> note stays G (127551). Send F0,1B -> note_active=0, half_period=0, pwm_out=0 next cycle.
5. Send 0D,0D,0D (typematic) -> muted=1 only. Send F0,0D, then 0D -> muted=0. While muted, pwm_out stays 0 with a note held.
6. Send E0,23 -> no note. Send E0,F0,23 -> no change. Assert reset low mid-tone at an arbitrary cycle -> all outputs 0 on the next edge.
